// File: rtl/axil_regfile.sv
// ----------------------------------------------------------------------------
// axil_regfile
// AXI4-lite slave that implements a bank of NUM_REGS software-visible
// registers. Write address and write data are captured into independent
// holding registers and committed together with byte strobes; every write
// gets exactly one B response and every read exactly one R response.
// Register contents are exported flat on reg_q, and a one-cycle pulse on
// reg_wr_pulse marks each register that was written.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   s_axil_aw*           write address channel (awprot ignored)
//   s_axil_w*            write data channel with byte strobes
//   s_axil_b*            write response channel (OKAY / SLVERR)
//   s_axil_ar*           read address channel (arprot ignored)
//   s_axil_r*            read data channel (OKAY / SLVERR)
//   reg_q                register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_pulse         one-cycle strobe per register written
// ----------------------------------------------------------------------------
module axil_regfile #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    STRB_WIDTH  = DATA_WIDTH / 8,
   parameter int                    NUM_REGS    = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
   input  logic [2:0]                     s_axil_awprot,
   input  logic                           s_axil_awvalid,
   output logic                           s_axil_awready,
   input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
   input  logic [STRB_WIDTH-1:0]          s_axil_wstrb,
   input  logic                           s_axil_wvalid,
   output logic                           s_axil_wready,
   output logic [1:0]                     s_axil_bresp,
   output logic                           s_axil_bvalid,
   input  logic                           s_axil_bready,
   input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
   input  logic [2:0]                     s_axil_arprot,
   input  logic                           s_axil_arvalid,
   output logic                           s_axil_arready,
   output logic [DATA_WIDTH-1:0]          s_axil_rdata,
   output logic [1:0]                     s_axil_rresp,
   output logic                           s_axil_rvalid,
   input  logic                           s_axil_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);

   localparam int OFF_W  = $clog2(STRB_WIDTH);
   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam int AIDX_W = ADDR_WIDTH - OFF_W;
   localparam logic [AIDX_W-1:0] NUM_REGS_A = AIDX_W'(NUM_REGS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                  aw_held_r;
   logic [AIDX_W-1:0]     aw_idx_r;
   logic                  w_held_r;
   logic [DATA_WIDTH-1:0] w_data_r;
   logic [STRB_WIDTH-1:0] w_strb_r;
   logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
   logic [NUM_REGS-1:0]   reg_wr_pulse_r;
   logic                  bvalid_r;
   logic [1:0]            bresp_r;
   logic                  rvalid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [1:0]            rresp_r;

   logic                  fire_s;
   logic                  awready_s;
   logic                  wready_s;
   logic                  arready_s;
   logic                  aw_hs_s;
   logic                  w_hs_s;
   logic                  ar_hs_s;
   logic [IDX_W-1:0]      wr_idx_s;
   logic                  wr_ok_s;
   logic [AIDX_W-1:0]     rd_aidx_s;
   logic [IDX_W-1:0]      rd_idx_s;
   logic                  rd_in_range_s;
   logic                  unused_s;

   // Protection bits and address byte-offset bits carry no meaning here.
   assign unused_s = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

   // Commit needs both halves of the write and a free (or freeing) B slot.
   // Readies include fire so a new beat can be accepted in the commit cycle.
   assign fire_s    = aw_held_r & w_held_r & (~bvalid_r | s_axil_bready);
   assign awready_s = rst & (~aw_held_r | fire_s);
   assign wready_s  = rst & (~w_held_r | fire_s);
   assign arready_s = rst & (~rvalid_r | s_axil_rready);
   assign aw_hs_s   = s_axil_awvalid & awready_s;
   assign w_hs_s    = s_axil_wvalid & wready_s;
   assign ar_hs_s   = s_axil_arvalid & arready_s;

   // Decode the held write index: in range and not read-only.
   always_comb begin
      wr_idx_s = aw_idx_r[IDX_W-1:0];
      if (aw_idx_r < NUM_REGS_A) begin
         wr_ok_s = ~RO_MASK[wr_idx_s];
      end else begin
         wr_ok_s = 1'b0;
      end
   end

   // Decode the incoming read index straight from the AR channel.
   always_comb begin
      rd_aidx_s     = s_axil_araddr[ADDR_WIDTH-1:OFF_W];
      rd_idx_s      = rd_aidx_s[IDX_W-1:0];
      rd_in_range_s = (rd_aidx_s < NUM_REGS_A);
   end

   // Write address holding register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         aw_held_r <= 1'b0;
         aw_idx_r  <= '0;
      end else if (aw_hs_s) begin
         aw_held_r <= 1'b1;
         aw_idx_r  <= s_axil_awaddr[ADDR_WIDTH-1:OFF_W];
      end else if (fire_s) begin
         aw_held_r <= 1'b0;
      end
   end

   // Write data holding register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         w_held_r <= 1'b0;
         w_data_r <= '0;
         w_strb_r <= '0;
      end else if (w_hs_s) begin
         w_held_r <= 1'b1;
         w_data_r <= s_axil_wdata;
         w_strb_r <= s_axil_wstrb;
      end else if (fire_s) begin
         w_held_r <= 1'b0;
      end
   end

   // Register bank with byte-strobe update; the pulse fires even for wstrb=0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= RESET_VALUE;
         end
         reg_wr_pulse_r <= '0;
      end else begin
         reg_wr_pulse_r <= '0;
         if (fire_s && wr_ok_s) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
               if (w_strb_r[k]) begin
                  regs_r[wr_idx_s][k*8 +: 8] <= w_data_r[k*8 +: 8];
               end
            end
            reg_wr_pulse_r[wr_idx_s] <= 1'b1;
         end
      end
   end

   // Write response: a fire replaces a response being accepted this cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bvalid_r <= 1'b0;
         bresp_r  <= RESP_OKAY;
      end else if (fire_s) begin
         bvalid_r <= 1'b1;
         bresp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_bready) begin
         bvalid_r <= 1'b0;
      end
   end

   // Read response: data sampled before any same-cycle write takes effect.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rvalid_r <= 1'b0;
         rdata_r  <= '0;
         rresp_r  <= RESP_OKAY;
      end else if (ar_hs_s) begin
         rvalid_r <= 1'b1;
         rdata_r  <= rd_in_range_s ? regs_r[rd_idx_s] : '0;
         rresp_r  <= rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_rready) begin
         rvalid_r <= 1'b0;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_flat
         assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
      end
   endgenerate

   assign s_axil_awready = awready_s;
   assign s_axil_wready  = wready_s;
   assign s_axil_arready = arready_s;
   assign s_axil_bvalid  = bvalid_r;
   assign s_axil_bresp   = bresp_r;
   assign s_axil_rvalid  = rvalid_r;
   assign s_axil_rdata   = rdata_r;
   assign s_axil_rresp   = rresp_r;
   assign reg_wr_pulse   = reg_wr_pulse_r;

endmodule

// File: tb/tb_axil_regfile.sv
// ----------------------------------------------------------------------------
// tb_axil_regfile
// Self-checking bench for axil_regfile (32-bit data, 16 registers, register 5
// read-only, reset value 0). A word-array model holds the expected register
// contents; directed scenarios are followed by a randomized read/write phase.
// ----------------------------------------------------------------------------
module tb_axil_regfile;

   localparam logic [15:0] RO = 16'h0020;

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  s_axil_awaddr;
   logic [2:0]   s_axil_awprot;
   logic         s_axil_awvalid;
   logic         s_axil_awready;
   logic [31:0]  s_axil_wdata;
   logic [3:0]   s_axil_wstrb;
   logic         s_axil_wvalid;
   logic         s_axil_wready;
   logic [1:0]   s_axil_bresp;
   logic         s_axil_bvalid;
   logic         s_axil_bready;
   logic [15:0]  s_axil_araddr;
   logic [2:0]   s_axil_arprot;
   logic         s_axil_arvalid;
   logic         s_axil_arready;
   logic [31:0]  s_axil_rdata;
   logic [1:0]   s_axil_rresp;
   logic         s_axil_rvalid;
   logic         s_axil_rready;
   logic [511:0] reg_q;
   logic [15:0]  reg_wr_pulse;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] model_regs [16];

   axil_regfile #(
      .DATA_WIDTH(32), .ADDR_WIDTH(16), .NUM_REGS(16),
      .RESET_VALUE(32'h0), .RO_MASK(RO)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
      .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
      .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
      .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
      .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
      .s_axil_bready(s_axil_bready),
      .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
      .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
      .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
      .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
      .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
   endfunction

   function automatic void model_write(input logic [15:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb, output logic [1:0] resp,
                                       output logic [15:0] pulse);
      int idx;
      idx = int'(addr) / 4;
      if (idx < 16 && RO[idx] == 1'b0) begin
         for (int k = 0; k < 4; k++)
            if (strb[k]) model_regs[idx][k*8 +: 8] = data[k*8 +: 8];
         resp  = 2'b00;
         pulse = 16'h1 << idx;
      end else begin
         resp  = 2'b10;
         pulse = 16'h0;
      end
   endfunction

   function automatic void model_read(input logic [15:0] addr, output logic [31:0] data,
                                      output logic [1:0] resp);
      int idx;
      idx = int'(addr) / 4;
      if (idx < 16) begin
         data = model_regs[idx];
         resp = 2'b00;
      end else begin
         data = 32'h0;
         resp = 2'b10;
      end
   endfunction

   function automatic logic [511:0] model_flat();
      logic [511:0] f;
      for (int i = 0; i < 16; i++) f[i*32 +: 32] = model_regs[i];
      return f;
   endfunction

   // Full write: AW and W after independent delays, then B two cycles after
   // the later handshake, checking response, pulse and register contents.
   task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
      bit aw_done, w_done, aw_hs, w_hs;
      int n;
      logic [1:0]  exp_resp;
      logic [15:0] exp_pulse;
      model_write(addr, data, strb, exp_resp, exp_pulse);
      aw_done = 1'b0; w_done = 1'b0; n = 0;
      s_axil_bready = 1'b1;
      while (!(aw_done && w_done) && n < 50) begin
         s_axil_awvalid = !aw_done && (n >= aw_dly);
         s_axil_awaddr  = addr;
         s_axil_wvalid  = !w_done && (n >= w_dly);
         s_axil_wdata   = data;
         s_axil_wstrb   = strb;
         @(negedge clk);
         aw_hs = s_axil_awvalid && s_axil_awready;
         w_hs  = s_axil_wvalid && s_axil_wready;
         @(posedge clk); #1;
         aw_done = aw_done | aw_hs;
         w_done  = w_done | w_hs;
         n++;
      end
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      check_val("wr_hs_done", {aw_done, w_done}, 2'b11);
      @(negedge clk);
      check_val("b_early", s_axil_bvalid, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("b_valid", s_axil_bvalid, 1'b1);
      check_val("b_resp", s_axil_bresp, exp_resp);
      check_val("wr_pulse", reg_wr_pulse, exp_pulse);
      check_val("reg_q", reg_q, model_flat());
      @(posedge clk); #1;
   endtask

   // Full read; rready is withheld for 'hold' cycles to test R stability.
   task automatic do_read(input logic [15:0] addr, input int hold);
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      bit hs;
      int n;
      model_read(addr, exp_d, exp_r);
      s_axil_rready = 1'b0;
      hs = 1'b0; n = 0;
      while (!hs && n < 50) begin
         s_axil_arvalid = 1'b1;
         s_axil_araddr  = addr;
         @(negedge clk);
         hs = s_axil_arready;
         @(posedge clk); #1;
         n++;
      end
      s_axil_arvalid = 1'b0;
      check_val("ar_hs_done", hs, 1'b1);
      for (int i = 0; i <= hold; i++) begin
         if (i == hold) s_axil_rready = 1'b1;
         @(negedge clk);
         check_val("r_valid", s_axil_rvalid, 1'b1);
         check_val("r_data", s_axil_rdata, exp_d);
         check_val("r_resp", s_axil_rresp, exp_r);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check_val("r_done", s_axil_rvalid, 1'b0);
      @(posedge clk); #1;
   endtask

   logic [15:0] t4_addr [5];
   logic [31:0] t4_data [5];
   logic [1:0]  bq [$];
   logic [1:0]  r_resp;
   logic [15:0] r_pulse;
   logic [31:0] r_data;
   logic [15:0] addr;
   int wi, cyc, got;
   bit hs;

   initial begin
      rst = 1'b0;
      s_axil_awaddr = 16'h0; s_axil_awprot = 3'b0; s_axil_awvalid = 1'b1;
      s_axil_wdata = 32'h0; s_axil_wstrb = 4'h0; s_axil_wvalid = 1'b1;
      s_axil_bready = 1'b1;
      s_axil_araddr = 16'h0; s_axil_arprot = 3'b0; s_axil_arvalid = 1'b1;
      s_axil_rready = 1'b1;
      model_reset();

      // 1: reset, readies low throughout, then read of 0x4
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_val("rst_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
         check_val("rst_valids", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
         check_val("rst_pulse", reg_wr_pulse, 16'h0);
         check_val("rst_reg_q", reg_q, model_flat());
         check_val("rst_rdata", {s_axil_rdata, s_axil_rresp, s_axil_bresp}, 36'h0);
      end
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
      rst = 1'b1;
      do_read(16'h0004, 0);

      // 2: W two cycles before AW, partial strobes
      do_write(16'h0008, 32'hDEADBEEF, 4'b0101, 2, 0);
      check_val("t2_reg2", reg_q[95:64], 32'h00AD00EF);

      // 3: out-of-range and read-only writes, out-of-range read
      do_write(16'h0040, 32'h12345678, 4'hF, 0, 0);
      do_write(16'h0014, 32'hA5A5A5A5, 4'hF, 1, 0);
      do_read(16'h0040, 1);
      do_read(16'h0014, 0);

      // 4: back-to-back writes with B stalled for 5 cycles, then streaming
      t4_addr = '{16'h0018, 16'h001C, 16'h0040, 16'h0020, 16'h0014};
      for (int i = 0; i < 5; i++) t4_data[i] = $urandom;
      wi = 0; cyc = 0; got = 0;
      while (got < 5 && cyc < 40) begin
         s_axil_bready  = (cyc >= 5);
         s_axil_awvalid = (wi < 5);
         s_axil_wvalid  = (wi < 5);
         if (wi < 5) begin
            s_axil_awaddr = t4_addr[wi];
            s_axil_wdata  = t4_data[wi];
            s_axil_wstrb  = 4'hF;
         end
         @(negedge clk);
         if (cyc >= 2 && cyc <= 4) begin
            check_val("t4_stall_rdy", {s_axil_awready, s_axil_wready}, 2'b00);
            check_val("t4_stall_b", {s_axil_bvalid, s_axil_bresp}, {1'b1, bq[0]});
         end
         if (cyc >= 5 && wi < 5)
            check_val("t4_sustain", {s_axil_awready, s_axil_wready}, 2'b11);
         hs = s_axil_awvalid && s_axil_awready && s_axil_wready;
         if (s_axil_bvalid && s_axil_bready) begin
            check_val("t4_bresp", s_axil_bresp, (bq.size() > 0) ? bq.pop_front() : 2'b11);
            got++;
         end
         @(posedge clk); #1;
         if (hs) begin
            model_write(t4_addr[wi], t4_data[wi], 4'hF, r_resp, r_pulse);
            bq.push_back(r_resp);
            wi++;
         end
         cyc++;
      end
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b1;
      check_val("t4_count", got, 5);
      check_val("t4_cycles", cyc, 10);
      check_val("t4_reg_q", reg_q, model_flat());

      // 5: read of reg 3 in the same cycle its write fires
      do_write(16'h000C, 32'h00000011, 4'hF, 0, 0);
      s_axil_awvalid = 1'b1; s_axil_awaddr = 16'h000C;
      s_axil_wvalid = 1'b1; s_axil_wdata = 32'h00000022; s_axil_wstrb = 4'hF;
      @(negedge clk);
      check_val("t5_wr_rdy", {s_axil_awready, s_axil_wready}, 2'b11);
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      model_read(16'h000C, r_data, r_resp);
      s_axil_arvalid = 1'b1; s_axil_araddr = 16'h000C; s_axil_rready = 1'b1;
      @(negedge clk);
      check_val("t5_ar_rdy", s_axil_arready, 1'b1);
      @(posedge clk); #1;
      s_axil_arvalid = 1'b0;
      model_write(16'h000C, 32'h00000022, 4'hF, r_resp, r_pulse);
      @(negedge clk);
      check_val("t5_rdata_old", {s_axil_rvalid, s_axil_rresp, s_axil_rdata}, {1'b1, 2'b00, r_data});
      check_val("t5_b", {s_axil_bvalid, s_axil_bresp, reg_wr_pulse}, {1'b1, r_resp, r_pulse});
      @(posedge clk); #1;
      do_read(16'h000C, 0);

      // 6: reset while B is stalled and an AW is held
      s_axil_bready = 1'b0;
      s_axil_awvalid = 1'b1; s_axil_awaddr = 16'h0024;
      s_axil_wvalid = 1'b1; s_axil_wdata = 32'hCAFEF00D; s_axil_wstrb = 4'hF;
      @(posedge clk); #1;
      s_axil_wvalid = 1'b0; s_axil_awaddr = 16'h0028;
      @(negedge clk);
      check_val("t6_aw2_rdy", s_axil_awready, 1'b1);
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0;
      @(negedge clk);
      check_val("t6_b_stuck", s_axil_bvalid, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_val("t6_rst_rdy", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      check_val("t6_b_drop", s_axil_bvalid, 1'b0);
      check_val("t6_reg_q", reg_q, model_flat());
      @(posedge clk); #1;
      s_axil_bready = 1'b1;
      s_axil_wvalid = 1'b1; s_axil_wdata = 32'h0BADC0DE; s_axil_wstrb = 4'b0011;
      @(posedge clk); #1;
      s_axil_wvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("t6_no_b", s_axil_bvalid, 1'b0);
         @(posedge clk); #1;
      end
      s_axil_awvalid = 1'b1; s_axil_awaddr = 16'h0000;
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0;
      model_write(16'h0000, 32'h0BADC0DE, 4'b0011, r_resp, r_pulse);
      @(negedge clk);
      check_val("t6_b_early", s_axil_bvalid, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("t6_b_new", {s_axil_bvalid, s_axil_bresp, reg_wr_pulse}, {1'b1, r_resp, r_pulse});
      check_val("t6_reg_q_new", reg_q, model_flat());
      @(posedge clk); #1;

      // randomized mix of reads and writes
      for (int it = 0; it < 80; it++) begin
         addr = 16'($urandom_range(0, 16'h4F));
         if ($urandom_range(0, 7) == 0) addr = addr | 16'hFF00;
         if ($urandom_range(0, 1) == 1)
            do_write(addr, $urandom, 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         else
            do_read(addr, int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
